// File: rtl/ram_arbiter_if.sv
// Requester-side handshake bundle for one RAM arbiter port.
interface ram_arbiter_if;
  logic        req;
  logic        we;
  logic        bw;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        err;

  // Requester (cache refill engine) side
  modport master (
    output req, we, bw, addr, wdata,
    input  rdata, ack, err
  );

  // Arbiter side
  modport slave (
    input  req, we, bw, addr, wdata,
    output rdata, ack, err
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-ported 32-bit RAM between two
// requesters; sequences the RAM strobes, drives/releases the data bus and
// rejects out-of-window addresses with an error ack.
module ram_arbiter #(
  parameter logic [31:0] START_ADDRESS = 32'h1001_0000,
  parameter int unsigned MEM_DEPTH     = 128,
  parameter int unsigned WAIT_CYCLES   = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  ram_arbiter_if.slave  m0,
  ram_arbiter_if.slave  m1,
  output logic [31:0]   ram_addr,
  inout  wire  [31:0]   ram_data,
  output logic          ram_ce_n,
  output logic          ram_we_n,
  output logic          ram_oe_n,
  output logic          ram_bw
);

  localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               port_q;
  logic               last_grant_q;
  logic               we_q;
  logic               err_pend_q;
  logic               drive_q;
  logic [31:0]        wdata_q;
  logic [31:0]        ram_addr_q;
  logic               ce_n_q;
  logic               we_n_q;
  logic               oe_n_q;
  logic               ram_bw_q;
  logic [31:0]        m0_rdata_q;
  logic [31:0]        m1_rdata_q;
  logic               m0_ack_q;
  logic               m1_ack_q;
  logic               m0_err_q;
  logic               m1_err_q;

  logic               req0;
  logic               req1;
  logic               sel_valid;
  logic               sel_port;
  logic               sel_we;
  logic               sel_bw;
  logic [31:0]        sel_addr;
  logic [31:0]        sel_wdata;
  logic [31:0]        sel_offset;
  logic               sel_in_range;

  // Arbitration and address window decode; a port being acked this cycle is
  // masked so a request still held during its ack cycle is not served twice.
  always_comb begin
    req0       = m0.req && !m0_ack_q;
    req1       = m1.req && !m1_ack_q;
    sel_valid  = req0 || req1;
    sel_port   = (req0 && req1) ? ~last_grant_q : req1;
    sel_we     = sel_port ? m1.we    : m0.we;
    sel_bw     = sel_port ? m1.bw    : m0.bw;
    sel_addr   = sel_port ? m1.addr  : m0.addr;
    sel_wdata  = sel_port ? m1.wdata : m0.wdata;
    sel_offset = sel_addr - START_ADDRESS;
    sel_in_range = (sel_addr >= START_ADDRESS) && (sel_offset < 32'(MEM_DEPTH));
  end

  // Access sequencer: grant, strobe window with wait states, completion ack.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      port_q       <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      err_pend_q   <= 1'b0;
      drive_q      <= 1'b0;
      wdata_q      <= '0;
      ram_addr_q   <= '0;
      ce_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      ram_bw_q     <= 1'b1;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_err_q     <= 1'b0;
      m1_err_q     <= 1'b0;
    end else begin
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      m0_err_q <= 1'b0;
      m1_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sel_valid) begin
            port_q       <= sel_port;
            last_grant_q <= sel_port;
            we_q         <= sel_we;
            wdata_q      <= sel_wdata;
            if (sel_in_range) begin
              state_q    <= ACCESS;
              cnt_q      <= CNT_W'(WAIT_CYCLES);
              err_pend_q <= 1'b0;
              ram_addr_q <= sel_addr;
              ram_bw_q   <= sel_bw;
              ce_n_q     <= 1'b0;
              oe_n_q     <= sel_we;
              we_n_q     <= ~sel_we;
              drive_q    <= sel_we;
            end else begin
              state_q    <= DONE;
              err_pend_q <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            if (!we_q) begin
              if (port_q) m1_rdata_q <= ram_data;
              else        m0_rdata_q <= ram_data;
            end
            ce_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            drive_q <= 1'b0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          if (port_q) begin
            m1_ack_q <= 1'b1;
            m1_err_q <= err_pend_q;
            if (err_pend_q && !we_q) m1_rdata_q <= '0;
          end else begin
            m0_ack_q <= 1'b1;
            m0_err_q <= err_pend_q;
            if (err_pend_q && !we_q) m0_rdata_q <= '0;
          end
          err_pend_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Data bus is driven only from the registered write-drive flag.
  assign ram_data = drive_q ? wdata_q : 32'bz;

  assign ram_addr = ram_addr_q;
  assign ram_ce_n = ce_n_q;
  assign ram_we_n = we_n_q;
  assign ram_oe_n = oe_n_q;
  assign ram_bw   = ram_bw_q;

  assign m0.rdata = m0_rdata_q;
  assign m0.ack   = m0_ack_q;
  assign m0.err   = m0_err_q;
  assign m1.rdata = m1_rdata_q;
  assign m1.ack   = m1_ack_q;
  assign m1.err   = m1_err_q;

endmodule
